// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : mult_div_unit
// Purpose  : Multi-cycle multiply / multiply-accumulate / divide unit holding
//            the architectural HI/LO pair, with busy/stall for the pipeline.
// Revision : 1.0  initial release
// ============================================================================
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic        flush,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall,
    output logic [31:0] out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_MADD  = 4'd3;
    localparam logic [3:0] OP_MADDU = 4'd4;
    localparam logic [3:0] OP_MSUB  = 4'd5;
    localparam logic [3:0] OP_MSUBU = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;
    localparam logic [3:0] OP_MFLO  = 4'd10;
    localparam logic [3:0] OP_DIV   = 4'd14;
    localparam logic [3:0] OP_DIVU  = 4'd15;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;

    logic             w_accept;
    logic             w_is_div;
    logic             w_sgn_mul;
    logic [63:0]      w_ea, w_eb, w_prod, w_acc, w_mul_res;
    logic             w_neg_a, w_neg_b;
    logic [31:0]      w_abs_a, w_abs_b, w_uq, w_ur, w_q, w_r;

    assign w_accept = start & ~flush & (state_q == S_IDLE);
    assign w_is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);

    // Low 64 bits of a signed product equal those of the sign-extended unsigned product.
    assign w_sgn_mul = (op_q == OP_MULT) || (op_q == OP_MADD) || (op_q == OP_MSUB);
    assign w_ea      = w_sgn_mul ? {{32{a_q[31]}}, a_q} : {32'd0, a_q};
    assign w_eb      = w_sgn_mul ? {{32{b_q[31]}}, b_q} : {32'd0, b_q};
    assign w_prod    = w_ea * w_eb;
    assign w_acc     = {hi_q, lo_q};

    always_comb begin
        w_mul_res = w_prod;
        case (op_q)
            OP_MADD, OP_MADDU: w_mul_res = w_acc + w_prod;
            OP_MSUB, OP_MSUBU: w_mul_res = w_acc - w_prod;
            default:           w_mul_res = w_prod;
        endcase
    end

    // Sign-magnitude divide sidesteps the 0x80000000 / -1 overflow case.
    assign w_neg_a = (op_q == OP_DIV) & a_q[31];
    assign w_neg_b = (op_q == OP_DIV) & b_q[31];
    assign w_abs_a = w_neg_a ? (32'd0 - a_q) : a_q;
    assign w_abs_b = w_neg_b ? (32'd0 - b_q) : b_q;
    assign w_uq    = w_abs_a / w_abs_b;
    assign w_ur    = w_abs_a % w_abs_b;

    always_comb begin
        w_q = (w_neg_a ^ w_neg_b) ? (32'd0 - w_uq) : w_uq;
        w_r = w_neg_a ? (32'd0 - w_ur) : w_ur;
        if (b_q == 32'd0) begin
            w_q = 32'hFFFF_FFFF;
            w_r = a_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    op_d = op;
                    a_d  = a;
                    b_d  = b;
                    case (op)
                        OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            state_d = S_RUN;
                            cnt_d   = CNT_W'(MULT_CYCLES - 1);
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = S_RUN;
                            cnt_d   = CNT_W'(DIV_CYCLES - 1);
                        end
                        OP_MTHI: hi_d = a;
                        OP_MTLO: lo_d = a;
                        default: ;
                    endcase
                end
            end
            S_RUN: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                    if (w_is_div) begin
                        hi_d = w_r;
                        lo_d = w_q;
                    end else begin
                        hi_d = w_mul_res[63:32];
                        lo_d = w_mul_res[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = (state_q == S_RUN);
    assign stall = start & busy & ~flush;
    assign out   = (op == OP_MFLO) ? lo_q : hi_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_div_unit
// Purpose  : Scoreboard bench for mult_div_unit against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_mult_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [3:0]  op;
    logic        flush;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic [31:0] out;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .op    (op),
        .flush (flush),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .stall (stall),
        .out   (out),
        .hi    (hi),
        .lo    (lo)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          ncyc;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference behaviour computed directly from the arithmetic definitions.
    function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                  input logic [31:0] ch, input logic [31:0] cl,
                                  output logic [31:0] nh, output logic [31:0] nl, output bit multi);
        logic [63:0]        acc, ux, uy, prod, r64;
        logic signed [63:0] sx, sy, sq, sr;
        acc = {ch, cl};
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        sx  = {{32{x[31]}}, x};
        sy  = {{32{y[31]}}, y};
        nh = ch; nl = cl; multi = 1'b0;
        case (o)
            4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6: begin
                multi = 1'b1;
                if (o == 4'd1 || o == 4'd3 || o == 4'd5) prod = sx * sy;
                else                                     prod = ux * uy;
                if (o <= 4'd2)      r64 = prod;
                else if (o <= 4'd4) r64 = acc + prod;
                else                r64 = acc - prod;
                nh = r64[63:32];
                nl = r64[31:0];
            end
            4'd14: begin
                multi = 1'b1;
                if (y == 32'd0) begin nh = x; nl = 32'hFFFF_FFFF; end
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    nl = sq[31:0];
                    nh = sr[31:0];
                end
            end
            4'd15: begin
                multi = 1'b1;
                if (y == 32'd0) begin nh = x; nl = 32'hFFFF_FFFF; end
                else begin nl = x / y; nh = x % y; end
            end
            4'd7: nh = x;
            4'd8: nl = x;
            default: ;
        endcase
    endfunction

    task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] nh, nl;
        bit          multi;
        exp_t        e;
        model(o, x, y, m_hi, m_lo, nh, nl, multi);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        if (multi) begin
            e.hi = nh; e.lo = nl; e.ncyc = (o >= 4'd14) ? DC : MC;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        start = 1'b0; op = 4'd0;
        m_hi = nh; m_lo = nl;
        check("busy_after_issue", 32'(busy), 32'(multi));
    endtask

    task automatic wait_idle();
        int k = 0;
        @(negedge clk);
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
        issue(o, x, y);
        wait_idle();
        check("hi_reg", hi, m_hi);
        check("lo_reg", lo, m_lo);
        op = 4'd10; #1;
        check("out_mflo", out, m_lo);
        op = 4'd9; #1;
        check("out_mfhi", out, m_hi);
        op = 4'd0;
    endtask

    // Monitor: each falling busy edge is a result landing; compare against the queue.
    initial begin
        bit   prev = 1'b0;
        int   cyc  = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
                cyc  = 0;
            end else begin
                if (busy) cyc++;
                else if (prev) begin
                    if (sb_q.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_completion: got hi=%h lo=%h expected none", hi, lo);
                    end else begin
                        e = sb_q.pop_front();
                        check("sb_hi", hi, e.hi);
                        check("sb_lo", lo, e.lo);
                        check("sb_busy_cycles", 32'(cyc), 32'(e.ncyc));
                    end
                    cyc = 0;
                end
                prev = busy;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          k;
        bit          fin;
        logic [3:0]  ro;
        logic [31:0] rx, ry;

        rst_n = 1'b0; start = 1'b0; op = 4'd0; flush = 1'b0; a = 32'd0; b = 32'd0;
        repeat (2) @(negedge clk);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_out", out, 32'd0);
        rst_n = 1'b1;

        // mthi then mfhi on the following cycle
        issue(4'd7, 32'h1234_5678, 32'd0);
        start = 1'b1; op = 4'd9;
        @(negedge clk);
        check("mfhi_after_mthi", out, 32'h1234_5678);
        start = 1'b0; op = 4'd0;

        run_op(4'd1, 32'hFFFF_FFFE, 32'd3);
        check("mult_hi", hi, 32'hFFFF_FFFF);
        check("mult_lo", lo, 32'hFFFF_FFFA);
        run_op(4'd2, 32'hFFFF_FFFE, 32'd3);
        check("multu_hi", hi, 32'h0000_0002);
        check("multu_lo", lo, 32'hFFFF_FFFA);
        run_op(4'd14, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", lo, 32'hFFFF_FFFD);
        check("div_hi", hi, 32'hFFFF_FFFF);
        run_op(4'd14, 32'h8000_0000, 32'hFFFF_FFFF);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'd0);
        run_op(4'd15, 32'd5, 32'd0);
        check("divu0_lo", lo, 32'hFFFF_FFFF);
        check("divu0_hi", hi, 32'd5);
        run_op(4'd14, 32'hFFFF_FF00, 32'd0);
        check("div0_hi", hi, 32'hFFFF_FF00);
        run_op(4'd7, 32'd0, 32'd0);
        run_op(4'd8, 32'd10, 32'd0);
        run_op(4'd3, 32'd3, 32'd4);
        check("madd_lo", lo, 32'd22);
        run_op(4'd6, 32'd1, 32'd23);
        check("msubu_hi", hi, 32'hFFFF_FFFF);
        check("msubu_lo", lo, 32'hFFFF_FFFF);

        // Starts during a busy divide stall and must not be accepted
        issue(4'd14, $urandom, $urandom | 32'd1);
        start = 1'b1; flush = 1'b0; k = 0; fin = 1'b0;
        while (!fin && k < 100) begin
            @(negedge clk);
            k++;
            if (busy) begin
                check("stall_while_busy", 32'(stall), 32'd1);
                op = k[0] ? 4'd7 : 4'd10;
                a  = $urandom;
            end else begin
                start = 1'b0; op = 4'd10; #1;
                check("mflo_after_div", out, m_lo);
                check("hi_after_stall", hi, m_hi);
                fin = 1'b1;
            end
        end
        check("stall_loop_done", 32'(fin), 32'd1);
        op = 4'd0;

        // Flushed starts during busy: no stall, no effect
        issue(4'd1, $urandom, $urandom);
        start = 1'b1; flush = 1'b1; op = 4'd8; a = $urandom;
        k = 0;
        while (k < 100) begin
            @(negedge clk);
            k++;
            if (!busy) break;
            check("flush_no_stall", 32'(stall), 32'd0);
        end
        start = 1'b0; flush = 1'b0; op = 4'd0;
        check("flush_hi", hi, m_hi);
        check("flush_lo", lo, m_lo);

        // Flushed starts while idle are dropped
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 4'd14; a = 32'hCAFE_F00D; b = 32'd3;
        @(negedge clk);
        check("flush_idle_busy", 32'(busy), 32'd0);
        op = 4'd7;
        @(negedge clk);
        start = 1'b0; flush = 1'b0; op = 4'd0;
        check("flush_idle_hi", hi, m_hi);

        for (int i = 0; i < 40; i++) begin
            ro = 4'($urandom_range(0, 15));
            rx = $urandom;
            case ($urandom_range(0, 7))
                0:       ry = 32'd0;
                1:       ry = 32'hFFFF_FFFF;
                2:       begin rx = 32'h8000_0000; ry = $urandom; end
                default: ry = $urandom;
            endcase
            run_op(ro, rx, ry);
        end

        // Reset in busy cycle 3 of a mult aborts it
        run_op(4'd7, 32'hA5A5_A5A5, 32'd0);
        issue(4'd1, $urandom | 32'd1, $urandom | 32'd1);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_hi", hi, 32'd0);
        check("abort_lo", lo, 32'd0);
        sb_q.delete();
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        check("no_late_hi", hi, 32'd0);
        check("no_late_lo", lo, 32'd0);
        check("no_late_busy", 32'(busy), 32'd0);

        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_div_unit.md
# mult_div_unit

Multiply/divide unit with the architectural HI/LO register pair, sitting in the execute stage directly downstream of the instruction decoder. It consumes the decoder's `MDStart`/`MDOp`/`MDOutSel` controls plus the two register-file operands. It runs multi-cycle multiply, multiply-accumulate and divide operations, and provides HI/LO reads for mfhi/mflo. It raises `busy`/`stall` so the pipeline holds any HI/LO-dependent instruction until a pending result lands.

## Interface
- `MULT_CYCLES`, 5: busy cycles for mult/multu/madd/maddu/msub/msubu (≥1).
- `DIV_CYCLES`, 10: busy cycles for div/divu (≥1).
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset; asynchronous and active-low.
- `start`  in  1  decoder `MDStart`; qualifies `op`.
- `op`  in  4  decoder `MDOp`:
  - 1 mult, 2 multu, 3 madd, 4 maddu, 5 msub, 6 msubu
  - 7 mthi, 8 mtlo, 9 mfhi, 10 mflo
  - 14 div, 15 divu
  - all other codes are no-ops.
- `flush`  in  1  cancels a `start` in the same cycle (excepting instruction); no effect on an operation already running.
- `a`  in  32  rs operand.
- `b`  in  32  rt operand.
- `busy`  out  1  a multi-cycle operation is pending.
- `stall`  out  1  `start & busy & ~flush`; the pipeline must hold the issuing instruction.
- `out`  out  32  `op==10` ? LO : HI (combinational; consumed when `MDOutSel`=1).
- `hi`, `lo`  out  32 each  architectural HI/LO registers, exposed for debug/bench.

## Operation
- State: `IDLE`, `RUN`. Down-counter `cnt`. `busy = (state==RUN)`.
- Accept condition: `start & ~flush & ~busy`. Operands and op are latched on the accepting edge. While `busy`, every `start` is not accepted and raises `stall`, regardless of op.
- mult/multu: {HI,LO} ← a×b, 64-bit; signed for op 1, unsigned for op 2.
- madd/maddu: {HI,LO} ← {HI,LO} + a×b.
- msub/msubu: {HI,LO} ← {HI,LO} − a×b.
  - For all accumulate ops, {HI,LO} is sampled when the result is written, not at issue. It cannot change in between because everything is stalled.
  - Arithmetic is modulo 2^64.
- div (signed):
  - LO ← quotient truncated toward zero; HI ← remainder carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu: unsigned quotient and remainder.
- Divide by zero (b=0), both signed and unsigned: LO=0xFFFFFFFF, HI=a. No exception.
- mthi/mtlo: HI (resp. LO) ← a on the accepting edge; single cycle, no `RUN`.
- mfhi/mflo: no state change; `out` is valid the same cycle.
- Result computation may be iterative or precomputed at issue and held. Only the write timing and bit-exact values are specified.
- Unlisted op codes with `start`: no state change, no busy.

## Timing
- Reset (asynchronous, `rst_n`=0): HI=0, LO=0, state=`IDLE`, `cnt`=0, `busy`=0, `stall`=0, `out`=0.
- Multi-cycle op accepted at edge E0:
  - `busy`=1 from E0 until edge E_N, where N = MULT_CYCLES or DIV_CYCLES.
  - At E_N, HI and LO are written together and `busy` falls.
  - New values are visible on `hi`/`lo`/`out` in the cycle after E_N. A new op can be accepted at E_N+1, giving back-to-back throughput of one op per N+1 cycles.
- mthi/mtlo are visible on `out` in the cycle after the accepting edge.
- `rst_n` asserted mid-operation aborts it; no HI/LO write occurs.
- `flush` together with `start` while `busy`: `stall`=0, the start is dropped, and the running op is unaffected.

## Test plan
- Reset → `hi`=`lo`=0, `busy`=0. Then mthi a=0x12345678 followed by mfhi → `out`=0x12345678 one cycle later.
- mult a=0xFFFFFFFE (−2), b=3 → `busy` high for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. Same operands with multu → HI=0x00000002, LO=0xFFFFFFFA.
- Signed div:
  - a=−7 (0xFFFFFFF9), b=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
  - divu a=5, b=0 → LO=0xFFFFFFFF, HI=5.
- HI=0, LO=10, then madd a=3, b=4 → LO=22. Then msubu a=1, b=23 → HI=0xFFFFFFFF, LO=0xFFFFFFFF.
- Issue mflo while a div is busy → `stall`=1 every cycle until `busy` falls. After that, `out` shows the new LO. Same case with `flush`=1 → `stall`=0.
- Pull `rst_n` low in busy cycle 3 of a mult → `busy`=0 and HI=LO=0 immediately; no late write afterward.
